pair_sum_reader: RTL and testbench

Sequential consumer on the read side of the shared two-lane byte interface `I`. It samples lanes `z` and `y` through modport `P1` under a valid/ready handshake, forms their 8-bit sum, and buffers the results in a small FIFO. Results are presented on a downstream valid/ready stream. It is the registered, flow-controlled counterpart to the combinational writers that drive `I` through modport `P2`.

---
 rtl/pair_sum_pkg.sv | 14 +
 rtl/I.sv | 11 +
 rtl/pair_sum_fifo.sv | 62 ++++++
 rtl/pair_sum_reader.sv | 69 ++++++
 tb/tb_pair_sum_reader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pair_sum_pkg.sv
// Shared types and the pair adder for pair_sum_reader.
// Holds lane/sum widths and the 9-bit sum helper.
package pair_sum_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [8:0] sum_t;

    localparam byte_t SUM_MAX = 8'hFF;

    function automatic sum_t f_sum(input byte_t a, input byte_t b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/I.sv
// Shared two-lane byte interface.
// P1 is the read side, P2 the write side.
interface I;

    logic [7:0] z;
    logic [7:0] y;

    modport P1 (input z, input y);
    modport P2 (output z, output y);

endinterface

// File: rtl/pair_sum_fifo.sv
// DEPTH x 8 result buffer with wrapping pointers.
// Occupancy is kept in a separate counter.
module pair_sum_fifo
    import pair_sum_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic                     pop,
    input  byte_t                    wdata,
    output byte_t                    rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t           mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !srst;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage is not reset; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (srst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pair_sum_reader.sv
// Reads lane pairs from I.P1, buffers their 8-bit sums.
// Macro PAIR_SUM_READER_SATURATE_EN selects saturate vs wrap.
module pair_sum_reader
    import pair_sum_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_srst,
    I.P1                             u_I,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_valid,
    output byte_t                    o_sum,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    sum_t  raw;
    byte_t res;
    byte_t head;
    logic  push;
    logic  pop;
    logic  full;
    logic  empty;

    assign raw = f_sum(u_I.z, u_I.y);

    // Map the 9-bit sum onto the stored byte.
    always_comb begin
        res = raw[7:0];
`ifdef PAIR_SUM_READER_SATURATE_EN
        if (raw[8]) begin
            res = SUM_MAX;
        end
`endif
    end

    assign o_ready = !i_srst && !full;
    assign o_valid = !empty;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign o_sum   = o_valid ? head : '0;

    pair_sum_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .srst  (i_srst),
        .push  (push),
        .pop   (pop),
        .wdata (res),
        .rdata (head),
        .count (o_count),
        .full  (full),
        .empty (empty)
    );

    // Sticky carry-out of any accepted pair; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            o_overflow <= 1'b0;
        end else if (push && raw[8]) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pair_sum_reader.sv
// Self-checking bench for pair_sum_reader.
// Table vectors, corner sequences, and random traffic vs a queue model.
module tb_pair_sum_reader;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk = 1'b0;
    logic          i_srst;
    logic          i_valid;
    logic          o_ready;
    logic          o_valid;
    logic [7:0]    o_sum;
    logic          i_ready;
    logic [CW-1:0] o_count;
    logic          o_overflow;

    I bus ();

    pair_sum_reader #(
        .DEPTH (DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_srst     (i_srst),
        .u_I        (bus),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .o_sum      (o_sum),
        .i_ready    (i_ready),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mq[$];
    bit         m_ov;
    bit         mchk;

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] z;
        logic [7:0] y;
        bit         rdy;
        int         cnt;
        logic [7:0] sum;
        bit         val;
        bit         ov;
        bit         rdyo;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [7:0] exp_sum(input logic [7:0] a,
                                           input logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef PAIR_SUM_READER_SATURATE_EN
        if (s > 255) return 8'hFF;
`endif
        return 8'(s % 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: a bounded queue; pop then push, decided before the edge.
    task automatic model_step();
        bit can_push;
        bit do_pop;
        if (i_srst) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            can_push = (mq.size() < DEPTH);
            do_pop   = (mq.size() > 0) && i_ready;
            if (do_pop) void'(mq.pop_front());
            if (i_valid && can_push) begin
                mq.push_back(exp_sum(bus.z, bus.y));
                if (int'(bus.z) + int'(bus.y) > 255) m_ov = 1'b1;
            end
        end
    endtask

    task automatic model_chk(input string tag);
        logic [7:0] h;
        h = (mq.size() > 0) ? mq[0] : 8'h00;
        chk({tag, ".count"}, 32'(o_count), 32'(mq.size()));
        chk({tag, ".valid"}, 32'(o_valid), 32'(mq.size() > 0));
        chk({tag, ".sum"}, 32'(o_sum), 32'(h));
        chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ov));
        chk({tag, ".ready"}, 32'(o_ready),
            32'(!i_srst && mq.size() < DEPTH));
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge i_clk);
        #1;
        if (mchk) model_chk(tag);
    endtask

    task automatic drive(input bit rst, input bit v, input logic [7:0] z,
                         input logic [7:0] y, input bit rdy);
        i_srst  = rst;
        i_valid = v;
        bus.z   = z;
        bus.y   = y;
        i_ready = rdy;
    endtask

    logic [7:0] satv;
    bit         hold;

    initial begin
        satv = exp_sum(8'hF0, 8'h20);
        mchk = 1'b0;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        //            rst v  z      y      rdy cnt sum    val ov rdyo
        tbl[0]  = '{1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0};
        tbl[1]  = '{0, 1, 8'h03, 8'h04, 0, 1, 8'h07, 1, 0, 1};
        tbl[2]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1};
        tbl[3]  = '{0, 1, 8'h01, 8'h01, 0, 1, 8'h02, 1, 0, 1};
        tbl[4]  = '{0, 1, 8'h02, 8'h02, 0, 2, 8'h02, 1, 0, 1};
        tbl[5]  = '{0, 1, 8'h03, 8'h03, 0, 3, 8'h02, 1, 0, 1};
        tbl[6]  = '{0, 1, 8'h04, 8'h04, 0, 4, 8'h02, 1, 0, 0};
        tbl[7]  = '{0, 1, 8'h05, 8'h05, 0, 4, 8'h02, 1, 0, 0};
        tbl[8]  = '{0, 1, 8'h05, 8'h05, 1, 3, 8'h04, 1, 0, 1};
        tbl[9]  = '{0, 1, 8'h05, 8'h05, 0, 4, 8'h04, 1, 0, 0};
        tbl[10] = '{0, 0, 8'h00, 8'h00, 1, 3, 8'h06, 1, 0, 1};
        tbl[11] = '{0, 0, 8'h00, 8'h00, 1, 2, 8'h08, 1, 0, 1};
        tbl[12] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h0A, 1, 0, 1};
        tbl[13] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1};
        tbl[14] = '{0, 1, 8'hF0, 8'h20, 0, 1, satv,  1, 1, 1};
        tbl[15] = '{0, 1, 8'h01, 8'h01, 1, 1, 8'h02, 1, 1, 1};
        tbl[16] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 1};

        repeat (2) cyc("init");

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].z, tbl[i].y, tbl[i].rdy);
            cyc("tbl");
            chk($sformatf("tbl%0d.count", i), 32'(o_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.sum", i), 32'(o_sum), 32'(tbl[i].sum));
            chk($sformatf("tbl%0d.valid", i), 32'(o_valid), 32'(tbl[i].val));
            chk($sformatf("tbl%0d.ovf", i), 32'(o_overflow), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d.ready", i), 32'(o_ready), 32'(tbl[i].rdyo));
        end

        // Reset mid-operation with three entries and undriven lanes.
        mchk = 1'b1;
        drive(0, 1, 8'h80, 8'h80, 0); cyc("xr.p0");
        drive(0, 1, 8'h01, 8'h02, 0); cyc("xr.p1");
        drive(0, 1, 8'h03, 8'h04, 0); cyc("xr.p2");
        chk("xr.pre_count", 32'(o_count), 32'd3);
        chk("xr.pre_ovf", 32'(o_overflow), 32'd1);
        drive(1, 1, 8'hxx, 8'hxx, 1); cyc("xr.rst");
        chk("xr.count", 32'(o_count), 32'd0);
        chk("xr.valid", 32'(o_valid), 32'd0);
        chk("xr.ovf", 32'(o_overflow), 32'd0);
        chk("xr.sum", 32'(o_sum), 32'h00);
        drive(0, 0, 8'hxx, 8'hxx, 0);
        cyc("xr.idle0");
        cyc("xr.idle1");
        chk("xr.idle_count", 32'(o_count), 32'd0);
        drive(0, 1, 8'h09, 8'h01, 0); cyc("xr.push");
        chk("xr.post_sum", 32'(o_sum), 32'h0A);
        chk("xr.post_count", 32'(o_count), 32'd1);

        // Sustained push+pop across several pointer wraps.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(0, 1, 8'(i + 1), 8'(i + 1), 1);
            cyc("ss");
            chk($sformatf("ss%0d.count", i), 32'(o_count), 32'd1);
            chk($sformatf("ss%0d.sum", i), 32'(o_sum), 32'(2 * (i + 1)));
        end

        // Random traffic; lanes held while a pair waits for o_ready.
        drive(1, 0, 8'h00, 8'h00, 0); cyc("rnd.rst");
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                i_valid = ($urandom_range(0, 3) != 0);
                bus.z   = 8'($urandom);
                bus.y   = 8'($urandom);
            end
            i_ready = ($urandom_range(0, 2) != 0);
            i_srst  = ($urandom_range(0, 59) == 0);
            hold    = i_valid && !o_ready && !i_srst;
            cyc("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
